// File: rtl/nmea_gga_pkg.sv
// Shared types and constants for the NMEA GGA sentence transmitter.
package nmea_gga_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_SEND    = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int SENTENCE_LEN = 74;
  localparam int BODY_LEN     = 68;

  // Body offsets (body index 0 is the 'G' after '$').
  localparam int OFF_TIME = 6;
  localparam int OFF_LAT  = 17;
  localparam int OFF_NS   = 27;
  localparam int OFF_LON  = 29;
  localparam int OFF_EW   = 40;
  localparam int OFF_TAIL = 41;

  localparam logic [47:0]  HDR_STR  = 48'("GPGGA,");
  localparam logic [215:0] TAIL_STR = 216'(",1,08,0.9,0545.4,M,46.9,M,,");
  localparam logic [39:0]  FRAC_STR = 40'(".000,");

  localparam logic [7:0] ASC_DOLLAR = 8'h24;
  localparam logic [7:0] ASC_STAR   = 8'h2A;
  localparam logic [7:0] ASC_CR     = 8'h0D;
  localparam logic [7:0] ASC_LF     = 8'h0A;
  localparam logic [7:0] ASC_DOT    = 8'h2E;
  localparam logic [7:0] ASC_COMMA  = 8'h2C;
  localparam logic [7:0] ASC_N      = 8'h4E;
  localparam logic [7:0] ASC_S      = 8'h53;
  localparam logic [7:0] ASC_E      = 8'h45;
  localparam logic [7:0] ASC_W      = 8'h57;

  // BCD digit to ASCII '0'..'9'.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  // Nibble to uppercase ASCII hex.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h37 + {4'h0, n};
    end
    return r;
  endfunction

  // Double-dabble correction for one BCD digit.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/nmea_gga_tx_bin2bcd_seq.sv
// Sequential 24-bit binary to 7-digit BCD converter (double dabble).
// One load cycle, then 24 shift/add-3 steps; done pulses once the result is final.
// Values above 9999999 overflow the 7-digit result.
module bin2bcd_seq
  import nmea_gga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [27:0] bcd
);

  logic [23:0] bin_q, bin_d;
  logic [27:0] bcd_q, bcd_d, adj_s;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;

  // Add-3 correction on every digit ahead of the next shift.
  always_comb begin
    adj_s = bcd_q;
    for (int i = 0; i < 7; i++) begin
      adj_s[i*4 +: 4] = add3(bcd_q[i*4 +: 4]);
    end
  end

  // Load, shift sequencing and completion pulse.
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load) begin
      bin_d  = bin_in;
      bcd_d  = 28'd0;
      cnt_d  = 5'd24;
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj_s[26:0], bin_q[23]};
      bin_d = {bin_q[22:0], 1'b0};
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= 24'd0;
      bcd_q  <= 28'd0;
      cnt_q  <= 5'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/nmea_gga_tx.sv
// NMEA GGA sentence transmitter: latches a fix, converts fields to ASCII
// decimal through one shared converter, and streams a 74-byte sentence with
// XOR checksum over a byte-wide UART send/busy handshake.
module nmea_gga_tx
  import nmea_gga_pkg::*;
#(
  parameter logic [23:0] SUBMIN_MAX  = 24'd599999,
  parameter logic [6:0]  LAT_DEG_MAX = 7'd90,
  parameter logic [7:0]  LON_DEG_MAX = 8'd180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  lat_deg,
  input  logic [23:0] lat_submins,
  input  logic        lat_north,
  input  logic [7:0]  lon_deg,
  input  logic [23:0] lon_submins,
  input  logic        lon_east,
  input  logic [23:0] time_bcd,
  output logic        busy,
  output logic        done,
  output logic        fmt_err,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy
);

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [7:0]  cks_q, cks_d, tx_data_q, tx_data_d;
  logic        busy_q, busy_d, done_q, done_d, fmt_err_q, fmt_err_d, tx_send_q, tx_send_d;
  logic [6:0]  lat_deg_q, lat_deg_d;
  logic [7:0]  lon_deg_q, lon_deg_d;
  logic [23:0] lat_sub_q, lat_sub_d, lon_sub_q, lon_sub_d, time_q, time_d;
  logic        lat_north_q, lat_north_d, lon_east_q, lon_east_d;
  logic [4:0]  step_q, step_d;
  logic [1:0]  sel_q, sel_d, wr_sel_q, wr_sel_d;
  logic [23:0] dig_lat_sub_q, dig_lat_sub_d, dig_lon_sub_q, dig_lon_sub_d;
  logic [7:0]  dig_lat_deg_q, dig_lat_deg_d;
  logic [11:0] dig_lon_deg_q, dig_lon_deg_d;

  logic        accept_s, range_err_s, time_err_s, conv_load_s, conv_busy_s, conv_done_s, conv_unused_s;
  logic [23:0] conv_in_s;
  logic [27:0] conv_bcd_s;
  logic [543:0] body_s;
  logic [9:0]  body_sel_s;
  logic [7:0]  byte_s;

  bin2bcd_seq u_conv (
    .clk    (clk),
    .rst    (rst),
    .load   (conv_load_s),
    .bin_in (conv_in_s),
    .busy   (conv_busy_s),
    .done   (conv_done_s),
    .bcd    (conv_bcd_s)
  );

  assign conv_load_s   = (state_q == ST_CONVERT) && (step_q == 5'd0);
  assign conv_unused_s = ^{conv_busy_s, conv_bcd_s[27:24]};

  // Range check of the live inputs, evaluated when start is sampled.
  always_comb begin
    time_err_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (time_bcd[i*4 +: 4] > 4'd9) begin
        time_err_s = 1'b1;
      end else begin
        time_err_s = time_err_s;
      end
    end
    range_err_s = (lat_deg > LAT_DEG_MAX) || (lon_deg > LON_DEG_MAX) ||
                  (lat_submins > SUBMIN_MAX) || (lon_submins > SUBMIN_MAX) || time_err_s;
  end

  // Converter source: lat submins, lon submins, lat degrees, lon degrees.
  always_comb begin
    case (sel_q)
      2'd0:    conv_in_s = lat_sub_q;
      2'd1:    conv_in_s = lon_sub_q;
      2'd2:    conv_in_s = {17'd0, lat_deg_q};
      2'd3:    conv_in_s = {16'd0, lon_deg_q};
      default: conv_in_s = 24'd0;
    endcase
  end

  // Assemble the 68-byte body and pick the byte for the current index.
  always_comb begin
    body_s = {HDR_STR,
              digit_ascii(time_q[23:20]), digit_ascii(time_q[19:16]), digit_ascii(time_q[15:12]),
              digit_ascii(time_q[11:8]),  digit_ascii(time_q[7:4]),   digit_ascii(time_q[3:0]),
              FRAC_STR,
              digit_ascii(dig_lat_deg_q[7:4]), digit_ascii(dig_lat_deg_q[3:0]),
              digit_ascii(dig_lat_sub_q[23:20]), digit_ascii(dig_lat_sub_q[19:16]), ASC_DOT,
              digit_ascii(dig_lat_sub_q[15:12]), digit_ascii(dig_lat_sub_q[11:8]),
              digit_ascii(dig_lat_sub_q[7:4]),   digit_ascii(dig_lat_sub_q[3:0]), ASC_COMMA,
              (lat_north_q ? ASC_N : ASC_S), ASC_COMMA,
              digit_ascii(dig_lon_deg_q[11:8]), digit_ascii(dig_lon_deg_q[7:4]), digit_ascii(dig_lon_deg_q[3:0]),
              digit_ascii(dig_lon_sub_q[23:20]), digit_ascii(dig_lon_sub_q[19:16]), ASC_DOT,
              digit_ascii(dig_lon_sub_q[15:12]), digit_ascii(dig_lon_sub_q[11:8]),
              digit_ascii(dig_lon_sub_q[7:4]),   digit_ascii(dig_lon_sub_q[3:0]), ASC_COMMA,
              (lon_east_q ? ASC_E : ASC_W),
              TAIL_STR};
    body_sel_s = {(7'd68 - idx_q), 3'b000};
    byte_s     = 8'h00;
    if (idx_q == 7'd0) begin
      byte_s = ASC_DOLLAR;
    end else if (idx_q <= 7'(BODY_LEN)) begin
      byte_s = body_s[body_sel_s +: 8];
    end else begin
      case (idx_q)
        7'd69:   byte_s = ASC_STAR;
        7'd70:   byte_s = hex_ascii(cks_q[7:4]);
        7'd71:   byte_s = hex_ascii(cks_q[3:0]);
        7'd72:   byte_s = ASC_CR;
        7'd73:   byte_s = ASC_LF;
        default: byte_s = 8'h00;
      endcase
    end
  end

  // Main sequencer: capture/check, convert, byte send/gap, done.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cks_d       = cks_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fmt_err_d   = 1'b0;
    tx_send_d   = 1'b0;
    tx_data_d   = tx_data_q;
    step_d      = step_q;
    sel_d       = sel_q;
    accept_s    = 1'b0;
    lat_deg_d   = lat_deg_q;
    lat_sub_d   = lat_sub_q;
    lat_north_d = lat_north_q;
    lon_deg_d   = lon_deg_q;
    lon_sub_d   = lon_sub_q;
    lon_east_d  = lon_east_q;
    time_d      = time_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lat_deg_d   = lat_deg;
          lat_sub_d   = lat_submins;
          lat_north_d = lat_north;
          lon_deg_d   = lon_deg;
          lon_sub_d   = lon_submins;
          lon_east_d  = lon_east;
          time_d      = time_bcd;
          if (range_err_s) begin
            fmt_err_d = 1'b1;
          end else begin
            accept_s = 1'b1;
            busy_d   = 1'b1;
            step_d   = 5'd0;
            sel_d    = 2'd0;
            state_d  = ST_CONVERT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (step_q == 5'd24) begin
          step_d = 5'd0;
          if (sel_q == 2'd3) begin
            state_d = ST_SEND;
          end else begin
            sel_d = sel_q + 2'd1;
          end
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_data_d = byte_s;
          tx_send_d = 1'b1;
          if ((idx_q >= 7'd1) && (idx_q <= 7'(BODY_LEN))) begin
            cks_d = cks_q ^ byte_s;
          end else begin
            cks_d = cks_q;
          end
          state_d = ST_GAP;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        idx_d = idx_q + 7'd1;
        if (idx_q == 7'(SENTENCE_LEN - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        idx_d   = 7'd0;
        cks_d   = 8'd0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Digit register file, filled in conversion order as results complete.
  always_comb begin
    dig_lat_sub_d = dig_lat_sub_q;
    dig_lon_sub_d = dig_lon_sub_q;
    dig_lat_deg_d = dig_lat_deg_q;
    dig_lon_deg_d = dig_lon_deg_q;
    wr_sel_d      = wr_sel_q;
    if (accept_s) begin
      wr_sel_d = 2'd0;
    end else if (conv_done_s) begin
      case (wr_sel_q)
        2'd0:    dig_lat_sub_d = conv_bcd_s[23:0];
        2'd1:    dig_lon_sub_d = conv_bcd_s[23:0];
        2'd2:    dig_lat_deg_d = conv_bcd_s[7:0];
        2'd3:    dig_lon_deg_d = conv_bcd_s[11:0];
        default: dig_lat_sub_d = dig_lat_sub_q;
      endcase
      wr_sel_d = wr_sel_q + 2'd1;
    end else begin
      wr_sel_d = wr_sel_q;
    end
  end

  // All state and output registers; reset aborts any sentence in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;      idx_q <= 7'd0;        cks_q <= 8'd0;
      busy_q <= 1'b0;          done_q <= 1'b0;       fmt_err_q <= 1'b0;
      tx_send_q <= 1'b0;       tx_data_q <= 8'h00;
      step_q <= 5'd0;          sel_q <= 2'd0;        wr_sel_q <= 2'd0;
      lat_deg_q <= 7'd0;       lat_sub_q <= 24'd0;   lat_north_q <= 1'b0;
      lon_deg_q <= 8'd0;       lon_sub_q <= 24'd0;   lon_east_q <= 1'b0;
      time_q <= 24'd0;
      dig_lat_sub_q <= 24'd0;  dig_lon_sub_q <= 24'd0;
      dig_lat_deg_q <= 8'd0;   dig_lon_deg_q <= 12'd0;
    end else begin
      state_q <= state_d;      idx_q <= idx_d;       cks_q <= cks_d;
      busy_q <= busy_d;        done_q <= done_d;     fmt_err_q <= fmt_err_d;
      tx_send_q <= tx_send_d;  tx_data_q <= tx_data_d;
      step_q <= step_d;        sel_q <= sel_d;       wr_sel_q <= wr_sel_d;
      lat_deg_q <= lat_deg_d;  lat_sub_q <= lat_sub_d; lat_north_q <= lat_north_d;
      lon_deg_q <= lon_deg_d;  lon_sub_q <= lon_sub_d; lon_east_q <= lon_east_d;
      time_q <= time_d;
      dig_lat_sub_q <= dig_lat_sub_d; dig_lon_sub_q <= dig_lon_sub_d;
      dig_lat_deg_q <= dig_lat_deg_d; dig_lon_deg_q <= dig_lon_deg_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign fmt_err = fmt_err_q;
  assign tx_data = tx_data_q;
  assign tx_send = tx_send_q;

endmodule

// File: tb/tb_nmea_gga_tx.sv
// Directed self-checking bench for nmea_gga_tx.
module tb_nmea_gga_tx;
  import nmea_gga_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, lat_north, lon_east, tx_busy;
  logic [6:0]  lat_deg;
  logic [7:0]  lon_deg;
  logic [23:0] lat_submins, lon_submins, time_bcd;
  logic        busy, done, fmt_err, tx_send;
  logic [7:0]  tx_data;

  int    n_assert = 0;
  int    n_fail   = 0;
  string rx_str;
  string exp_str;
  int    done_cnt, first_lat, hold_strobes, cnt_a, cnt_b, cnt_c;

  nmea_gga_tx dut (
    .clk(clk), .rst(rst), .start(start),
    .lat_deg(lat_deg), .lat_submins(lat_submins), .lat_north(lat_north),
    .lon_deg(lon_deg), .lon_submins(lon_submins), .lon_east(lon_east),
    .time_bcd(time_bcd), .busy(busy), .done(done), .fmt_err(fmt_err),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  // Golden sentence: '$', body, '*', XOR of body as two uppercase hex digits, CR LF.
  function automatic string full_sentence(input string body);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < body.len(); i++) c = c ^ body.getc(i);
    return $sformatf("$%s*%02X%c%c", body, c, 8'h0D, 8'h0A);
  endfunction

  task automatic set_fix(input logic [6:0] ld, input logic [23:0] ls, input logic ln,
                         input logic [7:0] od, input logic [23:0] os, input logic oe,
                         input logic [23:0] t);
    lat_deg = ld; lat_submins = ls; lat_north = ln;
    lon_deg = od; lon_submins = os; lon_east = oe; time_bcd = t;
  endtask

  // Pulse start (already set high by caller) and collect bytes until done.
  task automatic collect(input int hold_after, input int restart_at);
    int n;
    bit held;
    n = 0; held = 1'b0;
    rx_str = ""; done_cnt = 0; first_lat = -1; hold_strobes = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (restart_at > 0 && n == restart_at) begin start = 1'b1; lat_deg = 7'd55; end
      if (restart_at > 0 && n == restart_at + 1) start = 1'b0;
      if (tx_send) begin
        if (first_lat < 0) first_lat = n;
        rx_str = $sformatf("%s%c", rx_str, tx_data);
        if (!held && hold_after > 0 && rx_str.len() == hold_after) begin
          held = 1'b1; tx_busy = 1'b1;
          repeat (500) begin
            @(posedge clk); #1; n++;
            if (tx_send) hold_strobes++;
          end
          tx_busy = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 1'b0);
      end
    end
    check("done_seen", done_cnt, 1);
  endtask

  // Count strobes/busy/done/fmt_err over an idle window.
  task automatic quiet_window(input int cycles);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (tx_send) cnt_a++;
      if (busy) cnt_b++;
      if (done || fmt_err) cnt_c++;
    end
  endtask

  task automatic range_case(input string tag);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check({tag, "_fmt_err"}, fmt_err, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    quiet_window(150);
    check({tag, "_no_send"}, cnt_a, 0);
    check({tag, "_no_busy"}, cnt_b, 0);
    check({tag, "_single_pulse"}, cnt_c, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; tx_busy = 1'b0;
    set_fix(7'd0, 24'd0, 1'b0, 8'd0, 24'd0, 1'b0, 24'h000000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fmt_err", fmt_err, 1'b0);
    check("rst_tx_send", tx_send, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal sentence with latency and field position checks.
    set_fix(7'd42, 24'd123456, 1'b1, 8'd83, 24'd45678, 1'b0, 24'h153045);
    exp_str = full_sentence("GPGGA,153045.000,4212.3456,N,08304.5678,W,1,08,0.9,0545.4,M,46.9,M,,");
    start = 1'b1;
    collect(0, 0);
    check("nom_len", rx_str.len(), 74);
    check_str("nom_stream", rx_str, exp_str);
    check("nom_latency", first_lat, 102);
    check("nom_ns_pos", rx_str.getc(1 + OFF_NS), 8'h4E);
    check("nom_ew_pos", rx_str.getc(1 + OFF_EW), 8'h57);
    check("nom_cks_hi", rx_str.getc(70), exp_str.getc(70));
    check("nom_cks_lo", rx_str.getc(71), exp_str.getc(71));
    quiet_window(20);
    check("nom_after_send", cnt_a, 0);
    check("nom_after_done", cnt_c, 0);

    // Backpressure: tx_busy held for 500 cycles after byte 40.
    start = 1'b1;
    collect(40, 0);
    check("bp_hold_strobes", hold_strobes, 0);
    check("bp_len", rx_str.len(), 74);
    check_str("bp_stream", rx_str, exp_str);

    // Out-of-range rejections.
    set_fix(7'd91, 24'd123456, 1'b1, 8'd83, 24'd45678, 1'b0, 24'h153045);
    range_case("rng_lat_deg");
    set_fix(7'd42, 24'd123456, 1'b1, 8'd83, 24'd600000, 1'b0, 24'h153045);
    range_case("rng_lon_sub");
    set_fix(7'd42, 24'd123456, 1'b1, 8'd83, 24'd45678, 1'b0, 24'h15304A);
    range_case("rng_time");

    // Upper boundaries.
    set_fix(7'd90, 24'd599999, 1'b0, 8'd180, 24'd0, 1'b1, 24'h235959);
    start = 1'b1;
    collect(0, 0);
    check("bnd_len", rx_str.len(), 74);
    check_str("bnd_stream", rx_str,
      full_sentence("GPGGA,235959.000,9059.9999,S,18000.0000,E,1,08,0.9,0545.4,M,46.9,M,,"));

    // Reset at byte 30 aborts at once.
    set_fix(7'd42, 24'd123456, 1'b1, 8'd83, 24'd45678, 1'b0, 24'h153045);
    start = 1'b1;
    cnt_a = 0; cnt_b = 0;
    while (cnt_a < 30 && cnt_b < 1000) begin
      @(posedge clk); #1; cnt_b++;
      start = 1'b0;
      if (tx_send) cnt_a++;
    end
    check("rstmid_reached_30", cnt_a, 30);
    #2 rst = 1'b0;
    #1;
    check("rstmid_tx_send", tx_send, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Fresh sentence after reset (zero fields); a start while busy is ignored.
    set_fix(7'd0, 24'd0, 1'b1, 8'd7, 24'd1, 1'b0, 24'h000000);
    start = 1'b1;
    collect(0, 50);
    check("zero_len", rx_str.len(), 74);
    check_str("zero_stream", rx_str,
      full_sentence("GPGGA,000000.000,0000.0000,N,00700.0001,W,1,08,0.9,0545.4,M,46.9,M,,"));
    quiet_window(300);
    check("restart_not_queued", cnt_a, 0);
    check("restart_no_busy", cnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nmea_gga_tx.md
Name: nmea_gga_tx

Overview:
- Transmit-side counterpart of the GPS receive/parse path. Latches a position/time fix, converts it to ASCII decimal, and streams one fixed-width NMEA GGA sentence with XOR checksum over the existing byte-wide UART handshake (tx_data/tx_send/tx_busy).
- Used as a GPS emulator for bench and loopback, and as a telemetry downlink source.
- Sentence layout matches what the receive parser expects, so a loopback yields data_valid=1.

Parameters:
- SUBMIN_MAX, 599999, largest legal sub-minutes value (MMmmmm, minutes x 10000).
- LAT_DEG_MAX, 90, largest legal latitude degrees.
- LON_DEG_MAX, 180, largest legal longitude degrees.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request to send; sampled only in IDLE.
- lat_deg  in  7  latitude degrees, binary.
- lat_submins  in  24  latitude minutes x 10000, binary.
- lat_north  in  1  1=N, 0=S.
- lon_deg  in  8  longitude degrees, binary.
- lon_submins  in  24  longitude minutes x 10000, binary.
- lon_east  in  1  1=E, 0=W.
- time_bcd  in  24  hhmmss, packed BCD.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the LF byte is handed off.
- fmt_err  out  1  one-cycle pulse when start is rejected for out-of-range fields.
- tx_data  out  8  byte to UART.
- tx_send  out  1  one-cycle strobe; tx_data is valid in the same cycle.
- tx_busy  in  1  UART busy; the UART raises it the cycle after sampling tx_send.

Behaviour:
- Reset values: busy=0, done=0, fmt_err=0, tx_send=0, tx_data=8'h00, state=IDLE, checksum=0, byte index=0.
- Reset mid-sentence aborts immediately; there is no partial-sentence recovery.
- Sentence is exactly 74 bytes. After "$", body indices 0..67 are:
  - "GPGGA,"
  - hhmmss ".000" ","
  - DD MM "." mmmm ","
  - N/S ","
  - DDD MM "." mmmm ","
  - E/W
  - constant tail ",1,08,0.9,0545.4,M,46.9,M,," (27 bytes)
- After the body: "*", two uppercase hex checksum digits, CR, LF.
- Field positions: lat digits at body indices 17..25, N/S at 27, lon at 29..38, E/W at 40.
- Checksum = XOR of body bytes 0..67 (excludes "$" and "*"), accumulated as bytes are sent.
- State IDLE:
  - On start=1, capture all inputs.
  - If any of the following holds, pulse fmt_err next cycle and stay IDLE (no bytes sent): lat_deg>LAT_DEG_MAX, lon_deg>LON_DEG_MAX, either submins>SUBMIN_MAX, or any time_bcd nibble >9.
  - Otherwise busy=1 and go to CONVERT.
- State CONVERT:
  - Four sequential conversions through one shared converter: lat_submins -> 6 digits, lon_submins -> 6 digits, lat_deg -> 2 digits, lon_deg -> 3 digits.
  - Each conversion takes 25 cycles (1 load + 24 shift/add-3 steps).
  - Results are stored in a digit register file; then go to SEND.
- State SEND: when tx_busy=0, drive tx_data=byte[index], tx_send=1, XOR into checksum if 1<=index<=68, then go to GAP.
- State GAP: tx_send=0 for exactly one cycle. Increment index; if the sent byte was index 73, go to DONE, else go to SEND.
- State DONE: done=1 for one cycle, busy=0, clear index and checksum, go to IDLE.
- start outside IDLE is ignored (not queued).
- If tx_busy is held high in SEND, the FSM stalls indefinitely; tx_send stays 0 during the stall.
- Submins digits are emitted as MM.mmmm (high two digits, ".", low four). Degrees are zero-padded.
- Hex digits: 0-9 -> "0"-"9", 10-15 -> "A"-"F".
- Latency start -> first tx_send: 1 capture cycle + 100 convert cycles + 1 = 102 cycles, with tx_busy=0.

Decomposition:
- Shared package holds:
  - state encodings: IDLE, CONVERT, SEND, GAP, DONE
  - SENTENCE_LEN=74 and BODY_LEN=68
  - field offset constants
  - the 27-byte tail constant
  - ASCII constants "$", "*", CR, LF
- One sub-module: bin2bcd_seq, a 24-bit sequential double-dabble converter with load/busy/done and a 7-digit BCD output. It is reusable by the receive side for speed fields.

Test Plan:
- Nominal: lat 42 / 123456 / N, lon 83 / 45678 / W, time 24'h153045, start pulse -> exactly 74 tx_send strobes, stream "$GPGGA,153045.000,4212.3456,N,08304.5678,W,1,08,0.9,0545.4,M,46.9,M,,*hh\r\n"; hh matches the golden XOR model; done pulses once.
- Loopback: feed the stream into the receive parser -> data_valid=1, lat_deg=42, lat_submins=123456, lat_north=1, lon_deg=83, lon_submins=45678, lon_east=0.
- Range: lat_deg=91, or lon_submins=600000, or time_bcd=24'h15304A -> fmt_err pulse one cycle after start, zero tx_send, busy stays 0.
- Boundaries: lat 90/599999/S, lon 180/0/E -> "9059.9999,S,18000.0000,E". Lat 0/0 -> "0000.0000".
- Backpressure: hold tx_busy=1 for 500 cycles mid-sentence -> no tx_send during the hold; byte order intact; checksum unchanged.
- Reset (rst=0) at byte 30 -> tx_send=0 and busy=0 immediately. A new start after release sends a full 74-byte sentence from "$"; a start pulsed while busy is ignored.
